// File: rtl/tinyalu_pkg.sv
// Shared encodings and helpers for the TinyALU command engine.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100,
    RST_OP = 3'b111
  } operation_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RST   = 3'd3,
    ST_FLUSH = 3'd4
  } engine_state_t;

  localparam int unsigned OP_W = 3;

  // 101 and 110 have no ALU meaning and are answered with an error entry.
  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return (op == 3'b101) || (op == 3'b110);
  endfunction

  // Only ops that produce a result entry need a reserved result slot.
  function automatic logic op_needs_slot(input logic [OP_W-1:0] op);
    return !((op == NO_OP) || (op == RST_OP));
  endfunction

endpackage

// File: rtl/tinyalu_fifo.sv
// Synchronous FIFO with registered storage; head entry is presented directly.
module tinyalu_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy follows the net effect of push and pop in the same cycle.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Storage and pointers; pointers wrap naturally for power-of-2 depths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tinyalu_cmd_engine.sv
// Command engine: queues commands, sequences the TinyALU start/done
// handshake, detects done timeouts and returns results through a FIFO.
module tinyalu_cmd_engine
  import tinyalu_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  input  logic [2:0]          cmd_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [2:0]          alu_op,
  output logic                alu_start,
  output logic                alu_reset_n,
  input  logic                alu_done,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2*DATA_W-1:0] res_data,
  output logic [2:0]          res_op,
  output logic                res_err,
  output logic                busy
);

  localparam int unsigned RES_W  = 2 * DATA_W;
  localparam int unsigned CMD_FW = OP_W + 2 * DATA_W;
  localparam int unsigned RES_FW = 1 + OP_W + RES_W;
  localparam int unsigned CCW    = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned RCW    = $clog2(RES_DEPTH) + 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [RCW-1:0]   RES_FULL_CNT = RCW'(RES_DEPTH);
  localparam logic [TMR_W-1:0] TMO_CNT      = TMR_W'(TIMEOUT);

  engine_state_t     state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              rst_cnt_q, rst_cnt_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic              alu_start_q, alu_start_d;
  logic              alu_reset_n_q, alu_reset_n_d;

  logic [CMD_FW-1:0] cmd_head;
  logic [2:0]        cmd_head_op;
  logic              cmd_full, cmd_empty, cmd_pop, cmd_push;
  logic [CCW-1:0]    cmd_count;

  logic [RES_FW-1:0] res_head, res_push_data;
  logic              res_full, res_empty, res_push, res_pop, res_slot_free;
  logic [RCW-1:0]    res_count;

  assign cmd_ready   = !cmd_full;
  assign cmd_push    = cmd_valid && !cmd_full;
  assign cmd_head_op = cmd_head[CMD_FW-1 -: OP_W];

  assign res_valid     = !res_empty;
  assign res_pop       = res_valid && res_ready;
  assign res_slot_free = (res_count != RES_FULL_CNT);
  assign res_err       = res_head[RES_FW-1];
  assign res_op        = res_head[RES_FW-2 -: OP_W];
  assign res_data      = res_head[RES_W-1:0];

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_start   = alu_start_q;
  assign alu_reset_n = alu_reset_n_q;
  assign busy        = (state_q != ST_IDLE) || (cmd_count != '0);

  tinyalu_fifo #(.WIDTH(CMD_FW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (cmd_push),
    .data_i  ({cmd_op, cmd_b, cmd_a}),
    .pop_i   (cmd_pop),
    .data_o  (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_count)
  );

  tinyalu_fifo #(.WIDTH(RES_FW), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (res_push && !res_full),
    .data_i  (res_push_data),
    .pop_i   (res_pop),
    .data_o  (res_head),
    .full_o  (res_full),
    .empty_o (res_empty),
    .count_o (res_count)
  );

  // Sequencer: the result slot is reserved at pop time, so pushes never hit a full FIFO.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    rst_cnt_d     = rst_cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    alu_start_d   = alu_start_q;
    alu_reset_n_d = alu_reset_n_q;
    cmd_pop       = 1'b0;
    res_push      = 1'b0;
    res_push_data = '0;
    case (state_q)
      ST_IDLE: begin
        alu_start_d = 1'b0;
        if (!cmd_empty && (!op_needs_slot(cmd_head_op) || res_slot_free)) begin
          cmd_pop  = 1'b1;
          alu_a_d  = cmd_head[DATA_W-1:0];
          alu_b_d  = cmd_head[2*DATA_W-1:DATA_W];
          alu_op_d = cmd_head_op;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_is_illegal(alu_op_q)) begin
          res_push      = 1'b1;
          res_push_data = {1'b1, alu_op_q, {RES_W{1'b0}}};
          state_d       = ST_IDLE;
        end else if (alu_op_q == RST_OP) begin
          alu_reset_n_d = 1'b0;
          alu_start_d   = 1'b0;
          rst_cnt_d     = 1'b0;
          state_d       = ST_RST;
        end else if (alu_op_q == NO_OP) begin
          alu_start_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          alu_start_d = 1'b1;
          timer_d     = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (alu_done) begin
          res_push      = 1'b1;
          res_push_data = {1'b0, alu_op_q, alu_result};
          alu_start_d   = 1'b0;
          state_d       = ST_IDLE;
        end else if (timer_q == TMO_CNT) begin
          res_push      = 1'b1;
          res_push_data = {1'b1, alu_op_q, {RES_W{1'b0}}};
          alu_start_d   = 1'b0;
          state_d       = ST_FLUSH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RST: begin
        if (rst_cnt_q) begin
          alu_reset_n_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          rst_cnt_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        alu_start_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Engine state and ALU-side registers; reset drops alu_start immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      rst_cnt_q     <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      alu_start_q   <= 1'b0;
      alu_reset_n_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rst_cnt_q     <= rst_cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      alu_start_q   <= alu_start_d;
      alu_reset_n_q <= alu_reset_n_d;
    end
  end

endmodule
